// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: N-bit ALU with registered operands and results. Both sides use
// valid/ready handshakes. MUL is an iterative shift-add that takes N cycles.
// Reserved opcodes return r=0 and raise err.
//
// Handshake rule: a transfer happens on a rising clk edge where valid && ready.
// A producer holds its payload stable until that transfer has happened.
// in_ready does not depend on in_valid.
//
// Optional feature: define ALU_STICKY_FLAGS_EN to accumulate {C,Z,N,V} into
// sticky_flags. flag_clr clears them. Without the macro, sticky_flags is 0.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, a_in, b_in, opcode_in      operand side
//   out_valid/out_ready, r_out, c/z/n/v/err_out   result side
//   flag_clr, sticky_flags                        sticky flag accumulator
//   state_dbg                                     FSM state (0 IDLE, 1 EXEC, 2 DONE)
module alu_pipe_hs #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [3:0]   opcode_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r_out,
  output logic         c_out,
  output logic         z_out,
  output logic         n_out,
  output logic         v_out,
  output logic         err_out,
  input  logic         flag_clr,
  output logic [3:0]   sticky_flags,
  output logic [1:0]   state_dbg
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]   a_q, b_q;
  logic [3:0]     op_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] mcand_q, prod_q, prod_step;
  logic [N-1:0]   mplier_q;

  logic accept, handshake, is_mul, last_cycle;

  logic [N-1:0] alu_r;
  logic [N:0]   sum;
  logic         alu_c, alu_v, alu_err;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign handshake = out_valid && out_ready;
  assign state_dbg = state;

  // One shift-add step. The final step is folded straight into the result
  // register, so the product lands exactly N edges after accept.
  assign prod_step  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign is_mul     = (op_q == 4'd8);
  assign last_cycle = !is_mul || (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (last_cycle) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and multiply datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
    end else if (accept) begin
      a_q      <= a_in;
      b_q      <= b_in;
      op_q     <= opcode_in;
      cnt_q    <= '0;
      mcand_q  <= {{N{1'b0}}, a_in};
      prod_q   <= '0;
      mplier_q <= b_in;
    end else if (state == EXEC) begin
      cnt_q    <= cnt_q + CW'(1);
      prod_q   <= prod_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = '0;
    case (op_q)
      4'd0: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        alu_r = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (a_q[N-1] == b_q[N-1]) && (alu_r[N-1] != a_q[N-1]);
      end
      4'd1: begin
        alu_r = a_q - b_q;
        alu_c = (a_q >= b_q);
        alu_v = (a_q[N-1] != b_q[N-1]) && (alu_r[N-1] != a_q[N-1]);
      end
      4'd2:    alu_r = a_q & b_q;
      4'd3:    alu_r = a_q | b_q;
      4'd4:    alu_r = a_q ^ b_q;
      4'd5:    alu_r = ~a_q;
      4'd6:    alu_r = a_q << b_q[SW-1:0];
      4'd7:    alu_r = a_q >> b_q[SW-1:0];
      4'd8: begin
        alu_r = prod_step[N-1:0];
        alu_c = |prod_step[2*N-1:N];
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Result registers. They load only on the last EXEC cycle, so they stay
  // stable while DONE waits for out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      c_out   <= 1'b0;
      z_out   <= 1'b0;
      n_out   <= 1'b0;
      v_out   <= 1'b0;
      err_out <= 1'b0;
    end else if ((state == EXEC) && last_cycle) begin
      r_out   <= alu_r;
      c_out   <= alu_c;
      z_out   <= (alu_r == '0);
      n_out   <= alu_r[N-1];
      v_out   <= alu_v;
      err_out <= alu_err;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  // A clear takes priority over an update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           sticky_flags <= 4'b0000;
    else if (flag_clr)  sticky_flags <= 4'b0000;
    else if (handshake) sticky_flags <= sticky_flags | {c_out, z_out, n_out, v_out};
  end
`else
  logic unused_sticky;
  assign unused_sticky = flag_clr ^ handshake;
  assign sticky_flags  = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs (N=8). It combines an integer-arithmetic reference
// model, a scoreboard queue filled on every accept, and one compare process.
// The compare process checks result, flags, latency and stability on every
// cycle that out_valid is high. Directed literal checks pin the model and the
// cases called out for the block.
module tb_alu_pipe_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [3:0] opcode_in = '0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r_out;
  logic       c_out, z_out, n_out, v_out, err_out;
  logic       flag_clr = 1'b0;
  logic [3:0] sticky_flags;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int or_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random
  logic [12:0] exp_q[$];
  int          exp_cyc_q[$];
  logic        head_seen = 1'b0;
  logic [3:0]  exp_sticky = 4'b0000;

  alu_pipe_hs #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .opcode_in(opcode_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_out(r_out), .c_out(c_out), .z_out(z_out), .n_out(n_out), .v_out(v_out),
    .err_out(err_out), .flag_clr(flag_clr), .sticky_flags(sticky_flags),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives out_ready 1 ns after each rising edge, according to or_mode.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference model, packed as {r[7:0], C, Z, N, V, err}.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    int ua, ub, full, sa, sb, s;
    logic [7:0] r;
    logic c, v, err;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = '0; c = 1'b0; v = 1'b0; err = 1'b0;
    case (op)
      4'd0: begin full = ua + ub; r = 8'(full); c = (full > 255);
                  s = sa + sb; v = (s > 127) || (s < -128); end
      4'd1: begin full = ua - ub; r = 8'(full); c = (ua >= ub);
                  s = sa - sb; v = (s > 127) || (s < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin full = ua << (ub % 8); r = 8'(full); end
      4'd7: r = 8'(ua >> (ub % 8));
      4'd8: begin full = ua * ub; r = 8'(full); c = (full > 255); end
      default: err = 1'b1;
    endcase
    return {r, c, (r == 8'h00), r[7], v, err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call this 1 ns after a rising edge. It returns 1 ns after the accept edge.
  // waited holds the number of cycles in_ready was low before the accept.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      output int waited);
    in_valid = 1'b1; a_in = a; b_in = b; opcode_in = op; waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited >= 40) break;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, op));
    exp_cyc_q.push_back(cyc + 1 + ((op == 4'd8) ? 8 : 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output logic [12:0] got);
    int w;
    send(a, b, op, w);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("run_one_valid", 32'(out_valid), 32'd1);
    got = {r_out, c_out, z_out, n_out, v_out, err_out};
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_sticky = 4'b0000;
      check("reset_out_valid", 32'(out_valid), 32'd0);
    end else begin
      check("sticky", 32'(sticky_flags), 32'(exp_sticky));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("result", 32'({r_out, c_out, z_out, n_out, v_out, err_out}), 32'(exp_q[0]));
          if (!head_seen) begin
            check("latency", 32'(cyc), 32'(exp_cyc_q[0]));
            head_seen = 1'b1;
          end
          if (out_ready) begin
`ifdef ALU_STICKY_FLAGS_EN
            exp_sticky = exp_sticky | exp_q[0][4:1];
`endif
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (flag_clr) exp_sticky = 4'b0000;
    end
  end

  // ---------------- directed vectors {a, b, op} ----------------
  logic [19:0] vec [0:15] = '{
    20'hFF_01_0, 20'h80_80_0, 20'h80_01_1, 20'h00_01_1,
    20'hF0_3C_2, 20'hF0_0F_3, 20'hAA_FF_4, 20'h5A_00_5,
    20'h81_0B_6, 20'h81_07_6, 20'h81_0F_7, 20'hFF_FF_8,
    20'h0F_03_8, 20'h12_34_9, 20'h00_00_F, 20'h7F_01_0
  };

  // ---------------- main sequence ----------------
  initial begin
    logic [12:0] got;
    int w;

    // Reset state.
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_flags", 32'({c_out, z_out, n_out, v_out, err_out}), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);

    // Pin the model with hand-computed values.
    check("pin_add", 32'(model(8'h7F, 8'h01, 4'd0)), 32'({8'h80, 5'b00110}));
    check("pin_sub_eq", 32'(model(8'h05, 8'h05, 4'd1)), 32'({8'h00, 5'b11000}));
    check("pin_sub_neg", 32'(model(8'h03, 8'h05, 4'd1)), 32'({8'hFE, 5'b00100}));
    check("pin_mul", 32'(model(8'h10, 8'h10, 4'd8)), 32'({8'h00, 5'b11000}));
    check("pin_rsvd", 32'(model(8'h12, 8'h34, 4'hC)), 32'({8'h00, 5'b01001}));

    // Directed cases checked against literal values.
    step();
    run_one(8'h7F, 8'h01, 4'd0, got);
    check("add_7f_01", 32'(got), 32'({8'h80, 5'b00110}));
    step();
    run_one(8'h05, 8'h05, 4'd1, got);
    check("sub_5_5", 32'(got), 32'({8'h00, 5'b11000}));
    step();
    run_one(8'h03, 8'h05, 4'd1, got);
    check("sub_3_5", 32'(got), 32'({8'hFE, 5'b00100}));
    step();
    run_one(8'h12, 8'h34, 4'hC, got);
    check("rsvd_c", 32'(got), 32'({8'h00, 5'b01001}));

    // MUL: in_ready stays low for 8 cycles, then the result appears.
    step();
    send(8'h10, 8'h10, 4'd8, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mul_busy_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("mul_done_valid", 32'(out_valid), 32'd1);
    check("mul_done_result", 32'({r_out, c_out, z_out, n_out, v_out, err_out}),
          32'({8'h00, 5'b11000}));
    check("mul_ready_after", 32'(in_ready), 32'd1);
    drain();

    // Vector table, first back-to-back, then with random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      or_mode = (pass == 0) ? 0 : 2;
      step();
      for (int i = 0; i < 16; i++)
        send(vec[i][19:12], vec[i][11:4], vec[i][3:0], w);
      drain();
    end
    or_mode = 0;

    // Backpressure: result held for 10 cycles, then a zero-bubble handoff.
    or_mode = 1;
    step();
    send(8'h12, 8'h34, 4'd0, w);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    or_mode = 0;
    step();
    send(8'h01, 8'h01, 4'd0, w);
    check("b2b_no_bubble", 32'(w), 32'd0);
    drain();

    // Sticky flags: 0x80 (N) then 0x00 (Z), then clear.
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    send(8'h80, 8'h00, 4'd3, w);
    send(8'h00, 8'hFF, 4'd2, w);
    drain();
    @(negedge clk);
`ifdef ALU_STICKY_FLAGS_EN
    check("sticky_accum", 32'(sticky_flags), 32'h6);
`else
    check("sticky_tied", 32'(sticky_flags), 32'h0);
`endif
    step();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    @(negedge clk);
    check("sticky_cleared", 32'(sticky_flags), 32'h0);

    // Reset during MUL cycle 3: nothing stale may come out afterwards.
    step();
    run_one(8'h01, 8'h02, 4'd0, got);
    check("pre_rst_add", 32'(got), 32'({8'h03, 5'b00000}));
    step();
    send(8'h03, 8'h05, 4'd8, w);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    head_seen = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_r_out", 32'(r_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (12) @(negedge clk);
    check("post_rst_no_result", 32'(out_valid), 32'd0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
